// File: rtl/scl_clock_gen_pkg.sv
// Shared rate math for the SCL clock generator: half-period and counter sizing.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package scl_clock_gen_pkg;

  // Common operating points.
  localparam int FREQ_IN_DEFAULT = 20_000_000;
  localparam int FREQ_100K       = 100_000;
  localparam int FREQ_400K       = 400_000;

  // System clocks per half period of the output square wave (truncating).
  function automatic int calc_half(input int freq_in, input int freq_out);
    return freq_in / (2 * freq_out);
  endfunction

  // Counter width needed to count 0..half-1; never narrower than one bit.
  function automatic int cnt_width(input int half);
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

endpackage

// File: rtl/scl_clock_gen_if.sv
// Bundle of the generator's line input and its clock/strobe outputs.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
// master: the generator (reads sig_in, drives clk_out and all strobes).
// slave:  the consumer (drives sig_in, reads clk_out and all strobes).
interface scl_clock_gen_if;
  logic sig_in;
  logic clk_out;
  logic clk_out_rise;
  logic clk_out_fall;
  logic sig_rise;
  logic sig_fall;

  modport master (
    input  sig_in,
    output clk_out, clk_out_rise, clk_out_fall, sig_rise, sig_fall
  );

  modport slave (
    output sig_in,
    input  clk_out, clk_out_rise, clk_out_fall, sig_rise, sig_fall
  );
endinterface

// File: rtl/scl_clock_gen_edge_detect.sv
// Single-signal edge detector producing one-cycle rise/fall strobes.
// Latency: 0 cycles (strobes combinational from sig vs. its registered copy).
// Backpressure: none.
// Ports: clk, rst (async active-high), sig (input), rise/fall (strobes).
module scl_clock_gen_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig;
    end
  end

  // Gated by rst so no strobe can leak out while the block is held in reset.
  assign rise = sig  & ~prev_q & ~rst;
  assign fall = ~sig &  prev_q & ~rst;

endmodule

// File: rtl/scl_clock_gen.sv
// SCL timing front end: 50% clock divider plus edge strobes on clk_out and sig_in.
// Latency: clk_out strobes coincide with the new clk_out level; sig_in strobes 0 cycles
//          (2 cycles when SYNC_INPUT_EN is defined). Backpressure: none, free-running.
// Ports: clk, rst (async active-high), bus (master modport: sig_in in; clk_out,
//        clk_out_rise, clk_out_fall, sig_rise, sig_fall out).
// Build option: define SYNC_INPUT_EN to pass sig_in through a two-flop synchronizer.
module scl_clock_gen
  import scl_clock_gen_pkg::*;
#(
  parameter int FREQ_IN  = FREQ_IN_DEFAULT,
  parameter int FREQ_OUT = FREQ_100K
) (
  input  logic                  clk,
  input  logic                  rst,
  scl_clock_gen_if.master       bus
);

  localparam int               HALF    = calc_half(FREQ_IN, FREQ_OUT);
  localparam int               CNT_W   = cnt_width(HALF);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  if (HALF < 1) begin : g_half_chk
    $error("scl_clock_gen: FREQ_IN/(2*FREQ_OUT) must be at least 1");
  end

  // ---------------- divider ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    clk_out_d = clk_out_q;
    if (cnt_q == HALF_M1) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign bus.clk_out = clk_out_q;

  // ---------------- sig_in conditioning ----------------
  logic det_in;

`ifdef SYNC_INPUT_EN
  // sig_in may be asynchronous to clk; two flops settle metastability.
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.sig_in};
    end
  end

  assign det_in = sync_q[1];
`else
  // Caller guarantees sig_in is already synchronous to clk.
  assign det_in = bus.sig_in;
`endif

  // ---------------- edge strobes ----------------
  // clk_out is registered, so its strobes are glitch-free and land in the
  // first cycle the new level is visible.
  scl_clock_gen_edge_detect u_clk_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (clk_out_q),
    .rise (bus.clk_out_rise),
    .fall (bus.clk_out_fall)
  );

  scl_clock_gen_edge_detect u_sig_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (det_in),
    .rise (bus.sig_rise),
    .fall (bus.sig_fall)
  );

endmodule

// File: tb/tb_scl_clock_gen.sv
// Self-checking bench for scl_clock_gen: HALF=8 and HALF=1 instances side by side.
// Latency: n/a. Backpressure: n/a.
module tb_scl_clock_gen;

`ifdef SYNC_INPUT_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sig_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scl_clock_gen_if if8 ();
  scl_clock_gen_if if1 ();

  assign if8.sig_in = sig_in;
  assign if1.sig_in = sig_in;

  scl_clock_gen #(.FREQ_IN(16), .FREQ_OUT(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  scl_clock_gen #(.FREQ_IN(4), .FREQ_OUT(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n = number of rising clk edges seen since rst went low.
  // Divider: clk_out is bit 0 of n/h; an edge happens whenever n is a
  // nonzero multiple of h. Line strobes: compare the detector input in
  // this cycle with the previous one, where the detector input is the
  // sig_in sample from L cycles earlier (0 before that history exists).
  int n = 0;
  bit hist[$];

  function automatic bit eff(input int m);
    if (m < L) return 1'b0;
    return hist[m - L];
  endfunction

  task automatic chk_div(input string tag, input int h,
                         input logic co, input logic cr, input logic cf);
    int q;
    bit edge_now;
    q        = n / h;
    edge_now = (n > 0) && (n % h == 0);
    chk({tag, "_clk_out"},  int'(co), (q % 2 == 1) ? 1 : 0);
    chk({tag, "_clk_rise"}, int'(cr), (edge_now && q % 2 == 1) ? 1 : 0);
    chk({tag, "_clk_fall"}, int'(cf), (edge_now && q % 2 == 0) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      n = 0;
      hist.delete();
      chk("rst_clk_out8", int'(if8.clk_out), 0);
      chk("rst_clk_out1", int'(if1.clk_out), 0);
      chk("rst_strobes8", int'({if8.clk_out_rise, if8.clk_out_fall, if8.sig_rise, if8.sig_fall}), 0);
      chk("rst_strobes1", int'({if1.clk_out_rise, if1.clk_out_fall, if1.sig_rise, if1.sig_fall}), 0);
    end else begin
      bit er, ef;
      hist.push_back(sig_in);
      er = eff(n) & ~eff(n - 1);
      ef = ~eff(n) & eff(n - 1);
      chk_div("h8", 8, if8.clk_out, if8.clk_out_rise, if8.clk_out_fall);
      chk_div("h1", 1, if1.clk_out, if1.clk_out_rise, if1.clk_out_fall);
      chk("h8_sig_rise", int'(if8.sig_rise), int'(er));
      chk("h8_sig_fall", int'(if8.sig_fall), int'(ef));
      chk("h1_sig_rise", int'(if1.sig_rise), int'(er));
      chk("h1_sig_fall", int'(if1.sig_fall), int'(ef));
      n++;
    end
  end

  // ---------------- directed stimulus ----------------
  // sn mirrors n from the stimulus side: after tick() it is the index of
  // the cycle whose negedge was just reached.
  int sn;

  task automatic tick();
    @(negedge clk);
    sn++;
  endtask

  initial begin
    bit rise_v[8];
    bit fall_v[8];
    int nr, nf;

    rst    = 1'b1;
    sig_in = 1'b0;
    sn     = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_release_clk_out8", int'(if8.clk_out), 0);

    // Release with sig_in low.
    @(posedge clk); #1 rst = 1'b0; sn = -1;
    tick();  // cycle 0
    chk("c0_clk_out8", int'(if8.clk_out), 0);
    chk("c0_clk_out1", int'(if1.clk_out), 0);
    tick();  // cycle 1
    chk("c1_h1_clk_out", int'(if1.clk_out), 1);
    chk("c1_h1_rise", int'(if1.clk_out_rise), 1);
    chk("c1_h1_fall", int'(if1.clk_out_fall), 0);
    tick();  // cycle 2
    chk("c2_h1_clk_out", int'(if1.clk_out), 0);
    chk("c2_h1_fall", int'(if1.clk_out_fall), 1);
    while (sn < 7) tick();
    chk("c7_h8_clk_out", int'(if8.clk_out), 0);
    tick();
    chk("c8_h8_clk_out", int'(if8.clk_out), 1);
    chk("c8_h8_rise", int'(if8.clk_out_rise), 1);
    tick();
    chk("c9_h8_rise", int'(if8.clk_out_rise), 0);
    while (sn < 16) tick();
    chk("c16_h8_clk_out", int'(if8.clk_out), 0);
    chk("c16_h8_fall", int'(if8.clk_out_fall), 1);
    while (sn < 40) tick();

    // sig_in high for 3 cycles, then low.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 sig_in = (k < 3);
      tick();
      rise_v[k] = if8.sig_rise;
      fall_v[k] = if8.sig_fall;
    end
    nr = 0;
    nf = 0;
    for (int k = 0; k < 8; k++) begin
      nr += int'(rise_v[k]);
      nf += int'(fall_v[k]);
    end
    chk("sig3_rise_at_lat", int'(rise_v[L]), 1);
    chk("sig3_fall_at_lat", int'(fall_v[3 + L]), 1);
    chk("sig3_rise_count", nr, 1);
    chk("sig3_fall_count", nf, 1);

    // One-cycle-wide high, then a sub-cycle glitch between edges.
    @(posedge clk); #1 sig_in = 1'b1;
    tick();
    @(posedge clk); #1 sig_in = 1'b0;
    repeat (4) tick();
    @(posedge clk); #2 sig_in = 1'b1;
    #1 sig_in = 1'b0;
    repeat (4) tick();

    // Reset in the fifth cycle of a HALF=8 high phase, sig_in held high.
    while (sn % 16 != 12) tick();
    chk("mid_high_clk_out8", int'(if8.clk_out), 1);
    #2 rst = 1'b1; sig_in = 1'b1;
    #1;
    chk("async_clk_out8", int'(if8.clk_out), 0);
    chk("async_strobes8", int'({if8.clk_out_rise, if8.clk_out_fall, if8.sig_rise, if8.sig_fall}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; sn = -1;
    nr = 0;
    nf = 0;
    for (int k = 0; k <= 30; k++) begin
      tick();
      nr += int'(if8.sig_rise);
      nf += int'(if8.sig_fall);
      if (sn == L) chk("spurious_rise_cycle", int'(if8.sig_rise), 1);
      if (sn == 7) chk("rr_c7_clk_out8", int'(if8.clk_out), 0);
      if (sn == 8) chk("rr_c8_rise8", int'(if8.clk_out_rise), 1);
    end
    chk("held_high_rise_count", nr, 1);
    chk("held_high_fall_count", nf, 0);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
